// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: emits the CASET/RASET/RAMWR window header, then streams a raster frame of RGB565 pixels as hi/lo bytes.
// Latency: first header byte is presented the cycle after start; each pixel costs 4 cycles minimum (fetch, wait, hi, lo).
// Backpressure: tx_valid/tx_ready handshake; byte and dc are held stable until accepted, and the FSM stalls meanwhile.
module lcd_frame_writer #(
  parameter int unsigned SCREEN_WIDTH  = 32'd240,
  parameter int unsigned SCREEN_HEIGHT = 32'd240,
  parameter int unsigned X_OFFSET      = 32'd0,
  parameter int unsigned Y_OFFSET      = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pix_req,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  input  logic [15:0] pix_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_dc
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_PARAM, S_FETCH, S_WAIT, S_PIX_HI, S_PIX_LO, S_DONE
  } state_e;

  // Window bounds in panel coordinates, truncated to the 16-bit command fields.
  localparam logic [15:0] XS     = 16'(X_OFFSET);
  localparam logic [15:0] XE     = 16'(X_OFFSET + SCREEN_WIDTH - 32'd1);
  localparam logic [15:0] YS     = 16'(Y_OFFSET);
  localparam logic [15:0] YE     = 16'(Y_OFFSET + SCREEN_HEIGHT - 32'd1);
  // Last raster coordinates (no offset) used to detect row and frame end.
  localparam logic [15:0] X_LAST = 16'(SCREEN_WIDTH - 32'd1);
  localparam logic [15:0] Y_LAST = 16'(SCREEN_HEIGHT - 32'd1);

  state_e      state_q, state_d;
  logic [1:0]  cmd_idx_q, cmd_idx_d;
  logic [1:0]  par_cnt_q, par_cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] hold_q, hold_d;

  logic [7:0]  cmd_byte;
  logic [7:0]  par_byte;
  logic [15:0] win_s;
  logic [15:0] win_e;

  // Header byte selection: command by index, parameter by index and byte position.
  always_comb begin
    cmd_byte = 8'h2C;
    win_s    = XS;
    win_e    = XE;
    par_byte = 8'h00;
    case (cmd_idx_q)
      2'd0:    cmd_byte = 8'h2A;
      2'd1:    cmd_byte = 8'h2B;
      default: cmd_byte = 8'h2C;
    endcase
    if (cmd_idx_q != 2'd0) begin
      win_s = YS;
      win_e = YE;
    end
    case (par_cnt_q)
      2'd0:    par_byte = win_s[15:8];
      2'd1:    par_byte = win_s[7:0];
      2'd2:    par_byte = win_e[15:8];
      default: par_byte = win_e[7:0];
    endcase
  end

  // Next-state and output decode; outputs depend only on registered state so they are clean.
  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    par_cnt_d = par_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    hold_d    = hold_q;
    busy      = 1'b0;
    done      = 1'b0;
    pix_req   = 1'b0;
    pix_x     = 16'd0;
    pix_y     = 16'd0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_dc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CMD;
          cmd_idx_d = 2'd0;
        end
      end
      S_CMD: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = cmd_byte;
        if (tx_ready) begin
          if (cmd_idx_q == 2'd2) begin
            state_d = S_FETCH;
            x_d     = 16'd0;
            y_d     = 16'd0;
          end else begin
            state_d   = S_PARAM;
            par_cnt_d = 2'd0;
          end
        end
      end
      S_PARAM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = par_byte;
        if (tx_ready) begin
          par_cnt_d = par_cnt_q + 2'd1;
          if (par_cnt_q == 2'd3) begin
            cmd_idx_d = cmd_idx_q + 2'd1;
            state_d   = S_CMD;
          end
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        pix_req = 1'b1;
        pix_x   = x_q;
        pix_y   = y_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        hold_d  = pix_data;
        state_d = S_PIX_HI;
      end
      S_PIX_HI: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = hold_q[15:8];
        if (tx_ready) state_d = S_PIX_LO;
      end
      S_PIX_LO: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = hold_q[7:0];
        if (tx_ready) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + 16'd1;
            state_d = S_FETCH;
          end else if (y_q != Y_LAST) begin
            x_d     = 16'd0;
            y_d     = y_q + 16'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_idx_q <= 2'd0;
      par_cnt_q <= 2'd0;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      hold_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      par_cnt_q <= par_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: scoreboard bench for lcd_frame_writer with three parameterisations.
// Instance A: 3x4 frames (ramp and random pixels, random ready, extra starts, mid-frame reset).
// Instance B: 135x240 with offsets, header only; instance C: 1x1 frame.
module tb_lcd_frame_writer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic rst_a_n, start_a, rdy_a, busy_a, done_a, preq_a, tv_a, dc_a;
  logic [15:0] px_a, py_a, pd_a;
  logic [7:0]  td_a;
  // Instance B signals
  logic rst_b_n, start_b, rdy_b, busy_b, done_b, preq_b, tv_b, dc_b;
  logic [15:0] px_b, py_b, pd_b;
  logic [7:0]  td_b;
  // Instance C signals
  logic rst_c_n, start_c, rdy_c, busy_c, done_c, preq_c, tv_c, dc_c;
  logic [15:0] px_c, py_c, pd_c;
  logic [7:0]  td_c;

  lcd_frame_writer #(.SCREEN_WIDTH(3), .SCREEN_HEIGHT(4), .X_OFFSET(0), .Y_OFFSET(0)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .busy(busy_a), .done(done_a),
    .pix_req(preq_a), .pix_x(px_a), .pix_y(py_a), .pix_data(pd_a),
    .tx_valid(tv_a), .tx_ready(rdy_a), .tx_data(td_a), .tx_dc(dc_a));

  lcd_frame_writer #(.SCREEN_WIDTH(135), .SCREEN_HEIGHT(240), .X_OFFSET(52), .Y_OFFSET(40)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .busy(busy_b), .done(done_b),
    .pix_req(preq_b), .pix_x(px_b), .pix_y(py_b), .pix_data(pd_b),
    .tx_valid(tv_b), .tx_ready(rdy_b), .tx_data(td_b), .tx_dc(dc_b));

  lcd_frame_writer #(.SCREEN_WIDTH(1), .SCREEN_HEIGHT(1), .X_OFFSET(0), .Y_OFFSET(0)) dut_c (
    .clk(clk), .rst_n(rst_c_n), .start(start_c), .busy(busy_c), .done(done_c),
    .pix_req(preq_c), .pix_x(px_c), .pix_y(py_c), .pix_data(pd_c),
    .tx_valid(tv_c), .tx_ready(rdy_c), .tx_data(td_c), .tx_dc(dc_c));

  // Pixel sources: data appears the cycle after the fetch strobe.
  logic [15:0] mem_a [4][4];
  logic [15:0] mem_c;
  always @(posedge clk) if (preq_a) pd_a <= mem_a[py_a[1:0]][px_a[1:0]];
  always @(posedge clk) if (preq_c) pd_c <= mem_c;

  // Scoreboard queues of expected {dc, byte}
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic [8:0] exp_c[$];

  int   nbytes [3];
  int   ndone  [3];
  int   npreq  [3];
  bit   hold   [3];
  logic [8:0] hd [3];
  bit   rand_rdy;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [8:0] v);
    case (i)
      0:       exp_a.push_back(v);
      1:       exp_b.push_back(v);
      default: exp_c.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  function automatic logic [8:0] qpop(input int i);
    case (i)
      0:       return exp_a.pop_front();
      1:       return exp_b.pop_front();
      default: return exp_c.pop_front();
    endcase
  endfunction

  // Reference model: window header from offsets/size, then raster-order pixels hi/lo.
  task automatic model_frame(input int i, input int w, input int h, input int xo, input int yo, input bit pixels);
    logic [15:0] xs, xe, ys, ye, pv;
    xs = 16'(xo); xe = 16'(xo + w - 1);
    ys = 16'(yo); ye = 16'(yo + h - 1);
    push(i, 9'h02A);
    push(i, {1'b1, xs[15:8]}); push(i, {1'b1, xs[7:0]});
    push(i, {1'b1, xe[15:8]}); push(i, {1'b1, xe[7:0]});
    push(i, 9'h02B);
    push(i, {1'b1, ys[15:8]}); push(i, {1'b1, ys[7:0]});
    push(i, {1'b1, ye[15:8]}); push(i, {1'b1, ye[7:0]});
    push(i, 9'h02C);
    if (pixels) begin
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          pv = (i == 0) ? mem_a[2'(y)][2'(x)] : mem_c;
          push(i, {1'b1, pv[15:8]});
          push(i, {1'b1, pv[7:0]});
        end
      end
    end
  endtask

  task automatic fill_mem(input bit ramp);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        mem_a[y][x] = ramp ? {8'(y), 8'(x)} : 16'($urandom);
  endtask

  task automatic mon_one(input int i, input logic rstn, input logic v, input logic r,
                         input logic dc, input logic [7:0] d, input logic dn, input logic pr);
    if (!rstn) begin
      hold[i] = 1'b0;
      return;
    end
    if (hold[i]) check($sformatf("stable_inst%0d", i), 64'({v, dc, d}), 64'({1'b1, hd[i]}));
    if (v && r) begin
      nbytes[i]++;
      if (qsize(i) == 0) begin
        checks++; errors++;
        $display("FAIL extra_byte_inst%0d got=%03h exp=none", i, {dc, d});
      end else begin
        check($sformatf("byte%0d_inst%0d", nbytes[i], i), 64'({dc, d}), 64'(qpop(i)));
      end
    end
    hold[i] = v && !r;
    hd[i]   = {dc, d};
    if (dn) ndone[i]++;
    if (pr) npreq[i]++;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_one(0, rst_a_n, tv_a, rdy_a, dc_a, td_a, done_a, preq_a);
      mon_one(1, rst_b_n, tv_b, rdy_b, dc_b, td_b, done_b, preq_b);
      mon_one(2, rst_c_n, tv_c, rdy_c, dc_c, td_c, done_c, preq_c);
    end
  endtask

  task automatic ready_gen();
    rdy_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy_a = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_done(input int i, input int d0, input int budget, input bit extra);
    int n;
    n = 0;
    while (ndone[i] == d0 && n < budget) begin
      if (extra) start_a = busy_a & 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    start_a = 1'b0;
    if (ndone[i] == d0) begin
      checks++; errors++;
      $display("FAIL timeout_done_inst%0d waited=%0d exp=done_pulse", i, n);
    end
  endtask

  // Starts an A frame now (caller is just past a rising edge) and checks it end to end.
  task automatic run_frame_a(input bit extra, input string tag);
    int b0, d0;
    b0 = nbytes[0];
    d0 = ndone[0];
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check({tag, "_busy"}, 64'(busy_a), 64'(1));
    wait_done(0, d0, 2000, extra);
    check({tag, "_bytes"}, 64'(nbytes[0] - b0), 64'(35));
    check({tag, "_dones"}, 64'(ndone[0] - d0), 64'(1));
    check({tag, "_idle"}, 64'(busy_a), 64'(0));
    check({tag, "_qempty"}, 64'(exp_a.size()), 64'(0));
  endtask

  initial begin
    int n;
    rst_a_n = 0; rst_b_n = 0; rst_c_n = 0;
    start_a = 0; start_b = 0; start_c = 0;
    rdy_b = 1; rdy_c = 1; rand_rdy = 0;
    pd_b = 16'h0; mem_c = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      nbytes[i] = 0; ndone[i] = 0; npreq[i] = 0; hold[i] = 0; hd[i] = '0;
    end
    fork
      monitor();
      ready_gen();
    join_none
    repeat (3) @(posedge clk); #1;
    check("reset_outs_a", 64'({busy_a, done_a, preq_a, tv_a, dc_a, td_a, px_a, py_a}), 64'(0));
    check("reset_outs_c", 64'({busy_c, done_c, preq_c, tv_c, dc_c, td_c, px_c, py_c}), 64'(0));
    rst_a_n = 1; rst_b_n = 1; rst_c_n = 1;
    @(posedge clk); #1;

    // Frame 1: ramp pixels, ready high
    fill_mem(1'b1);
    model_frame(0, 3, 4, 0, 0, 1'b1);
    run_frame_a(1'b0, "f1");

    // Frame 2: ramp pixels, random ready
    rand_rdy = 1'b1;
    model_frame(0, 3, 4, 0, 0, 1'b1);
    run_frame_a(1'b0, "f2");

    // Frame 3: starts in the first IDLE cycle after DONE, random pixels, extra starts while busy
    fill_mem(1'b0);
    model_frame(0, 3, 4, 0, 0, 1'b1);
    run_frame_a(1'b1, "f3");

    // Frame 4: aborted by reset while pixel 5 (x=1,y=1) is being fetched
    fill_mem(1'b0);
    model_frame(0, 3, 4, 0, 0, 1'b1);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (!(preq_a && px_a == 16'd1 && py_a == 16'd1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL timeout_pixel5 waited=%0d exp=pix_req_at_1_1", n);
    end
    rst_a_n = 1'b0;
    #1;
    check("midrst_outs_a", 64'({busy_a, done_a, preq_a, tv_a, dc_a, td_a, px_a, py_a}), 64'(0));
    exp_a.delete();
    repeat (3) @(posedge clk); #1;
    check("midrst_hold_a", 64'({busy_a, done_a, preq_a, tv_a, dc_a, td_a, px_a, py_a}), 64'(0));
    rst_a_n = 1'b1;
    @(posedge clk); #1;

    // Frame 5: clean frame after the abort
    fill_mem(1'b0);
    model_frame(0, 3, 4, 0, 0, 1'b1);
    run_frame_a(1'b0, "f5");
    rand_rdy = 1'b0;

    // Instance B: offset window header only, then reset before any pixel byte
    model_frame(1, 135, 240, 52, 40, 1'b0);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (nbytes[1] < 11 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    rst_b_n = 1'b0;
    check("b_hdr_bytes", 64'(nbytes[1]), 64'(11));
    check("b_qempty", 64'(exp_b.size()), 64'(0));
    @(posedge clk); #1;
    rst_b_n = 1'b1;

    // Instance C: 1x1 frame
    model_frame(2, 1, 1, 0, 0, 1'b1);
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    check("c_busy", 64'(busy_c), 64'(1));
    wait_done(2, 0, 200, 1'b0);
    check("c_bytes", 64'(nbytes[2]), 64'(13));
    check("c_pixreq", 64'(npreq[2]), 64'(1));
    check("c_qempty", 64'(exp_c.size()), 64'(0));

    repeat (20) @(posedge clk); #1;
    check("a_done_total", 64'(ndone[0]), 64'(4));
    check("a_bytes_quiet", 64'(exp_a.size()), 64'(0));
    check("c_done_total", 64'(ndone[2]), 64'(1));
    check("b_no_done", 64'(ndone[1]), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
